fsmc_frame_writer: RTL

Upstream of the `control`/LED-bank chain: captures MCU parallel-bus (FSMC, asynchronous SRAM mode) write cycles from the a*/d*/ne*/nwe/nbl* pins.
Assembles 16-bit halfwords into 32-bit LED frame words and stores them in a double-buffered pixel RAM.
Swaps buffers on a software commit, synchronised to the controller's frame start.
The controller reads front-buffer words through a registered read port.

---
 rtl/fsmc_frame_writer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fsmc_frame_writer.sv
// fsmc_frame_writer: captures FSMC async-SRAM write cycles into a double-buffered
// 32-bit LED frame RAM; buffers exchange on a committed frame_start.
// Optional build macro FSMC_FRAME_WRITER_BYTE_LANES_EN: honour bus_nbl byte lanes
// (high-half writes then merge with the stored RAM word via read-modify-write).
module fsmc_frame_writer #(
    parameter  int unsigned AW    = 20,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] bus_addr,
    input  logic [15:0]   bus_data,
    input  logic          bus_ne,
    input  logic          bus_nwe,
    input  logic [1:0]    bus_nbl,
    input  logic          frame_start,
    input  logic [IW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          swap,
    output logic          pending,
    output logic          overrun
);

    // RAM index: {buffer select, word index}
    localparam int unsigned RW = IW + 1;

    logic          ne_s1, ne_s2, nwe_s1, nwe_s2, nwe_d;
    logic [AW-1:0] addr_p1, addr_p2, addr_h;
    logic [15:0]   data_p1, data_p2, data_h;
    logic [1:0]    nbl_p1, nbl_p2, nbl_h;
    logic [1:0]    fill;
    logic          armed;

    logic          front_sel;
    logic [15:0]   staging;
    logic          h_valid;
    logic [IW-1:0] h_idx;
    logic [31:0]   h_word;

    logic [31:0]   mem [2*DEPTH];

    logic          wr_en_c;
    logic [RW-1:0] wr_addr_c;
    logic [31:0]   wr_data_c;
    logic [15:0]   stg_next_c;

    // Strobe synchronisers, aligned bus pipeline and post-reset arming
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ne_s1   <= 1'b1;
            ne_s2   <= 1'b1;
            nwe_s1  <= 1'b1;
            nwe_s2  <= 1'b1;
            nwe_d   <= 1'b1;
            addr_p1 <= '0;
            addr_p2 <= '0;
            data_p1 <= '0;
            data_p2 <= '0;
            nbl_p1  <= '0;
            nbl_p2  <= '0;
            fill    <= '0;
            armed   <= 1'b0;
        end else begin
            ne_s1   <= bus_ne;
            ne_s2   <= ne_s1;
            nwe_s1  <= bus_nwe;
            nwe_s2  <= nwe_s1;
            nwe_d   <= nwe_s2;
            addr_p1 <= bus_addr;
            addr_p2 <= addr_p1;
            data_p1 <= bus_data;
            data_p2 <= data_p1;
            nbl_p1  <= bus_nbl;
            nbl_p2  <= nbl_p1;
            fill    <= {fill[0], 1'b1};
            // only a genuinely sampled nwe high arms edge detection
            armed   <= armed | (fill[1] & nwe_s2);
        end
    end

    // Hold the bus sample from the last cycle the synced strobe was low
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_h <= '0;
            data_h <= '0;
            nbl_h  <= '0;
        end else if (!nwe_s2) begin
            addr_h <= addr_p2;
            data_h <= data_p2;
            nbl_h  <= nbl_p2;
        end
    end

    // Write detect and address decode
    wire wr_c      = armed & ~nwe_d & nwe_s2 & ~ne_s2;
    wire pix_c     = wr_c & ~addr_h[AW-1] & (addr_h[AW-2:IW+1] == '0);
    wire reg_c     = wr_c & addr_h[AW-1] & (addr_h[AW-2:0] == '0);
    wire lo_c      = pix_c & ~addr_h[0];
    wire hi_c      = pix_c & addr_h[0];
    wire commit_c  = reg_c & data_h[0];
    wire clr_c     = reg_c & data_h[1];
    wire do_swap_c = frame_start & (pending | commit_c);

`ifdef FSMC_FRAME_WRITER_BYTE_LANES_EN
    wire [15:0] lane_m_c = {{8{~nbl_h[1]}}, {8{~nbl_h[0]}}};
    assign stg_next_c = (data_h & lane_m_c) | (staging & ~lane_m_c);
`else
    logic unused_nbl;
    assign unused_nbl = ^nbl_h;
    assign stg_next_c = data_h;
`endif

    // Staging, buffer select, commit/swap bookkeeping and pixel hold register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            staging   <= '0;
            front_sel <= 1'b0;
            swap      <= 1'b0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            h_valid   <= 1'b0;
            h_idx     <= '0;
            h_word    <= '0;
        end else begin
            if (lo_c) staging <= stg_next_c;
            if (do_swap_c) front_sel <= ~front_sel;
            swap    <= do_swap_c;
            pending <= do_swap_c ? 1'b0 : (commit_c ? 1'b1 : pending);
            if (commit_c && pending) overrun <= 1'b1;
            else if (clr_c)          overrun <= 1'b0;
            // one-cycle hold lets a write in the swap cycle target the new back buffer
            h_valid <= hi_c;
            if (hi_c) begin
                h_idx  <= addr_h[IW:1];
                h_word <= {data_h, staging};
            end
        end
    end

`ifdef FSMC_FRAME_WRITER_BYTE_LANES_EN
    logic          r_valid;
    logic [RW-1:0] r_addr;
    logic [31:0]   r_word;
    logic [1:0]    r_nbl;
    logic [31:0]   r_old;
    logic [1:0]    h_nbl;

    // Read-modify-write stage: buffer fixed when the stored word is fetched
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_nbl   <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_word  <= '0;
            r_nbl   <= '0;
        end else begin
            if (hi_c) h_nbl <= nbl_h;
            r_valid <= h_valid;
            if (h_valid) begin
                r_addr <= {~front_sel, h_idx};
                r_word <= h_word;
                r_nbl  <= h_nbl;
            end
        end
    end

    // Fetch of the existing back-buffer word for byte merging
    always_ff @(posedge clk) begin
        if (h_valid) r_old <= mem[{~front_sel, h_idx}];
    end

    assign wr_en_c   = r_valid;
    assign wr_addr_c = r_addr;
    assign wr_data_c = {r_nbl[1] ? r_old[31:24] : r_word[31:24],
                        r_nbl[0] ? r_old[23:16] : r_word[23:16],
                        r_word[15:0]};
`else
    assign wr_en_c   = h_valid;
    assign wr_addr_c = {~front_sel, h_idx};
    assign wr_data_c = h_word;
`endif

    // Pixel RAM write port (contents not reset)
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_addr_c] <= wr_data_c;
    end

    // Registered front-buffer read port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rd_data <= '0;
        else         rd_data <= mem[{front_sel, rd_addr}];
    end

endmodule
